// File: rtl/ov7670_cfg_pkg.sv
// Shared definitions for the OV7670 register-table sequencer, its ROM and the SCCB write engine.
package ov7670_cfg_pkg;

  localparam logic [15:0] CFG_END        = 16'hFFFF;
  localparam logic [15:0] CFG_DELAY      = 16'hFFF0;
  localparam logic [7:0]  CAM_WRITE_ADDR = 8'h42;

  typedef enum logic [3:0] {
    ST_IDLE        = 4'd0,
    ST_FETCH       = 4'd1,
    ST_DECODE      = 4'd2,
    ST_WAIT_RDY    = 4'd3,
    ST_ISSUE       = 4'd4,
    ST_WAIT_ACCEPT = 4'd5,
    ST_WAIT_DONE   = 4'd6,
    ST_DELAY       = 4'd7,
    ST_NEXT        = 4'd8,
    ST_DONE        = 4'd9
  } cfg_state_t;

  // Number of clk cycles in one delay-marker pause.
  function automatic logic [31:0] delay_cycles(input int unsigned clk_freq,
                                               input int unsigned delay_ms);
    return 32'(clk_freq / 1000 * delay_ms);
  endfunction

endpackage

// File: rtl/ov7670_config_rom.sv
// Synchronous register table for OV7670 bring-up: {reg, value} per entry, CFG_END terminated.
import ov7670_cfg_pkg::*;

module ov7670_config_rom #(
  parameter int ROM_AW = 8
) (
  input  logic              clk,
  input  logic [ROM_AW-1:0] rom_addr,
  output logic [15:0]       rom_data
);

  // COM7 reset first, then a pause so the sensor settles before the RGB565 setup.
  function automatic logic [15:0] table_entry(input logic [31:0] idx);
    case (idx)
      32'd0:   return 16'h1280;
      32'd1:   return CFG_DELAY;
      32'd2:   return 16'h1204;
      32'd3:   return 16'h1100;
      32'd4:   return 16'h0C00;
      32'd5:   return 16'h3E00;
      32'd6:   return 16'h40D0;
      32'd7:   return 16'h3A04;
      32'd8:   return 16'h8C00;
      32'd9:   return 16'h1438;
      32'd10:  return 16'h4F80;
      32'd11:  return 16'h5080;
      32'd12:  return 16'h5100;
      32'd13:  return 16'h5222;
      32'd14:  return 16'h535E;
      32'd15:  return 16'h5480;
      32'd16:  return 16'h589E;
      default: return CFG_END;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    rom_data <= table_entry(32'(rom_addr));
  end

endmodule

// File: rtl/ov7670_config_seq.sv
// Walks the register table and issues one SCCB write per entry, honouring delay and end markers.
import ov7670_cfg_pkg::*;

module ov7670_config_seq #(
  parameter int unsigned CLK_FREQ = 25000000,
  parameter int unsigned DELAY_MS = 10,
  parameter int          ROM_AW   = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cfg_start,
  output logic              cfg_busy,
  output logic              cfg_done,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  input  logic              sccb_ready,
  output logic              sccb_start,
  output logic [7:0]        sccb_addr,
  output logic [7:0]        sccb_data,
  output logic [ROM_AW-1:0] entry_count
);

  localparam logic [31:0] DELAY_LOAD = delay_cycles(CLK_FREQ, DELAY_MS) - 32'd1;

  cfg_state_t  state;
  cfg_state_t  state_next;
  logic [31:0] delay_cnt;
  logic        is_end;
  logic        is_delay;
  logic        last_addr;

  assign is_end    = (rom_data == CFG_END);
  assign is_delay  = (rom_data == CFG_DELAY);
  assign last_addr = &rom_addr;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  // sccb_start is qualified by ready and reset so it can never fire into a busy or resetting engine.
  always_comb begin
    state_next = state;
    sccb_start = 1'b0;
    unique case (state)
      ST_IDLE:        if (cfg_start) state_next = ST_FETCH;
      ST_FETCH:       state_next = ST_DECODE;
      ST_DECODE: begin
        if (is_end)        state_next = ST_DONE;
        else if (is_delay) state_next = ST_DELAY;
        else               state_next = ST_WAIT_RDY;
      end
      ST_WAIT_RDY:    if (sccb_ready) state_next = ST_ISSUE;
      ST_ISSUE: begin
        if (sccb_ready) begin
          sccb_start = reset_n;
          state_next = ST_WAIT_ACCEPT;
        end else begin
          state_next = ST_WAIT_RDY;
        end
      end
      ST_WAIT_ACCEPT: if (!sccb_ready) state_next = ST_WAIT_DONE;
      ST_WAIT_DONE:   if (sccb_ready) state_next = ST_NEXT;
      ST_DELAY:       if (delay_cnt == '0) state_next = ST_NEXT;
      ST_NEXT:        state_next = last_addr ? ST_DONE : ST_FETCH;
      ST_DONE:        state_next = ST_IDLE;
      default:        state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cfg_busy    <= 1'b0;
      cfg_done    <= 1'b0;
      rom_addr    <= '0;
      entry_count <= '0;
      sccb_addr   <= '0;
      sccb_data   <= '0;
      delay_cnt   <= '0;
    end else begin
      if (state == ST_IDLE && cfg_start) begin
        rom_addr    <= '0;
        entry_count <= '0;
        cfg_done    <= 1'b0;
        cfg_busy    <= 1'b1;
      end
      if (state == ST_DECODE && is_delay) begin
        delay_cnt <= DELAY_LOAD;
      end else if (state == ST_DELAY && delay_cnt != '0) begin
        delay_cnt <= delay_cnt - 32'd1;
      end
      if (state == ST_DECODE && !is_end && !is_delay) begin
        sccb_addr <= rom_data[15:8];
        sccb_data <= rom_data[7:0];
      end
      if (sccb_start) begin
        entry_count <= entry_count + ROM_AW'(1);
      end
      // The address saturates at the last entry; NEXT sends the pass to DONE instead of wrapping.
      if (state == ST_NEXT && !last_addr) begin
        rom_addr <= rom_addr + ROM_AW'(1);
      end
      if (state == ST_DONE) begin
        cfg_busy <= 1'b0;
        cfg_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ov7670_config_seq.sv
// Bench for ov7670_config_seq: table-walk reference model, write-engine model and directed/random passes.
import ov7670_cfg_pkg::*;

module tb_ov7670_config_seq;

  localparam int CLK_FREQ  = 1000000;
  localparam int DELAY_MS  = 1;
  localparam int ROM_AW    = 2;
  localparam int DEPTH     = 1 << ROM_AW;
  localparam int DELAY_CYC = CLK_FREQ / 1000 * DELAY_MS;
  localparam logic [15:0] PROD_HEAD [DEPTH] = '{16'h1280, 16'hFFF0, 16'h1204, 16'h1100};

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              cfg_start = 1'b0;
  logic              cfg_busy;
  logic              cfg_done;
  logic [ROM_AW-1:0] rom_addr;
  logic [15:0]       rom_data;
  logic [15:0]       tb_rom_q;
  logic [15:0]       prod_rom_q;
  logic              sccb_ready;
  logic              sccb_start;
  logic [7:0]        sccb_addr;
  logic [7:0]        sccb_data;
  logic [ROM_AW-1:0] entry_count;

  always #5 clk = ~clk;

  ov7670_config_seq #(
    .CLK_FREQ (CLK_FREQ),
    .DELAY_MS (DELAY_MS),
    .ROM_AW   (ROM_AW)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cfg_start   (cfg_start),
    .cfg_busy    (cfg_busy),
    .cfg_done    (cfg_done),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .sccb_ready  (sccb_ready),
    .sccb_start  (sccb_start),
    .sccb_addr   (sccb_addr),
    .sccb_data   (sccb_data),
    .entry_count (entry_count)
  );

  ov7670_config_rom #(.ROM_AW(ROM_AW)) u_rom (
    .clk      (clk),
    .rom_addr (rom_addr),
    .rom_data (prod_rom_q)
  );

  // Substitutable table with the same one-cycle read latency as the real ROM.
  logic [15:0] tbl [DEPTH];
  bit          use_prod = 1'b0;
  always @(posedge clk) tb_rom_q <= tbl[rom_addr];
  assign rom_data = use_prod ? prod_rom_q : tb_rom_q;

  // Write engine: drops ready the cycle after it samples start, stays busy busy_len cycles.
  int eng_left = 0;
  int busy_len = 50;
  bit hold_low = 1'b0;
  always @(posedge clk) begin
    if (sccb_start && sccb_ready) eng_left <= busy_len;
    else if (eng_left > 0)        eng_left <= eng_left - 1;
  end
  assign sccb_ready = (eng_left == 0) && !hold_low;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit rst_prev = 1'b0;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_prev <= !reset_n;
  end

  function automatic void check_output(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference model: the writes a pass must produce are the table entries in order,
  // skipping pause markers, stopping at the end marker or after the last entry.
  logic [15:0] exp_q [$];
  logic [15:0] obs_log [$];
  int          start_cycles [$];
  bit          active = 1'b0;
  bit          done_flag = 1'b0;
  bit          fresh = 1'b0;
  int          seen = 0;
  int          last_total = 0;
  int          prev_addr = 0;
  logic [15:0] last_wr = '0;

  function automatic void build_expected();
    logic [15:0] e;
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) begin
      e = use_prod ? PROD_HEAD[i] : tbl[i];
      if (e == CFG_END) break;
      if (e != CFG_DELAY) exp_q.push_back(e);
    end
  endfunction

  always @(negedge clk) begin
    if (rst_prev) begin
      check_output("reset_busy",   32'(cfg_busy), 0);
      check_output("reset_done",   32'(cfg_done), 0);
      check_output("reset_start",  32'(sccb_start), 0);
      check_output("reset_addr",   32'(rom_addr), 0);
      check_output("reset_count",  32'(entry_count), 0);
      check_output("reset_wrdata", 32'({sccb_addr, sccb_data}), 0);
      active = 1'b0; done_flag = 1'b0; fresh = 1'b0; last_total = 0;
      exp_q.delete();
    end else if (!reset_n) begin
      check_output("start_in_reset", 32'(sccb_start), 0);
    end else begin
      if (active && cfg_done) begin
        check_output("done_writes_left", 32'(exp_q.size()), 0);
        active = 1'b0; done_flag = 1'b1; last_total = seen;
      end
      if (active) begin
        check_output("busy_in_pass", 32'(cfg_busy), 1);
        check_output("entry_count", 32'(entry_count), 32'(seen % DEPTH));
        if (fresh) begin
          check_output("rom_addr_restart", 32'(rom_addr), 0);
          fresh = 1'b0;
        end
        check_output("rom_addr_no_wrap", 32'(int'(rom_addr) >= prev_addr), 1);
        prev_addr = int'(rom_addr);
        if (seen > 0 && eng_left > 0)
          check_output("wr_stable", 32'({sccb_addr, sccb_data}), 32'(last_wr));
        if (sccb_start) begin
          check_output("start_with_ready", 32'(sccb_ready), 1);
          if (exp_q.size() == 0) begin
            check_output("extra_write", 32'(sccb_start), 0);
          end else begin
            check_output("write_payload", 32'({sccb_addr, sccb_data}), 32'(exp_q.pop_front()));
          end
          last_wr = {sccb_addr, sccb_data};
          obs_log.push_back(last_wr);
          start_cycles.push_back(cyc);
          seen++;
        end
      end else begin
        check_output("idle_busy",  32'(cfg_busy), 0);
        check_output("idle_done",  32'(cfg_done), 32'(done_flag));
        check_output("idle_count", 32'(entry_count), 32'(last_total % DEPTH));
        check_output("idle_start", 32'(sccb_start), 0);
      end
      if (cfg_start && !active) begin
        active = 1'b1; done_flag = 1'b0; fresh = 1'b1;
        seen = 0; prev_addr = 0;
        build_expected();
        obs_log.delete();
        start_cycles.delete();
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(output int k);
    k = cyc;
    cfg_start = 1'b1;
    tick(1);
    cfg_start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int c;
    c = 0;
    while (!cfg_done && c < budget) begin
      tick(1);
      c++;
    end
    if (!cfg_done) check_output({name, "_timeout"}, 32'(cfg_done), 1);
    tick(1);
  endtask

  task automatic wait_writes(input int n, input int budget);
    int c;
    c = 0;
    while (obs_log.size() < n && c < budget) begin
      tick(1);
      c++;
    end
    if (obs_log.size() < n) check_output("wait_writes_timeout", 32'(obs_log.size()), 32'(n));
  endtask

  task automatic apply_stimulus(input logic [15:0] e0, input logic [15:0] e1,
                                input logic [15:0] e2, input logic [15:0] e3);
    tbl[0] = e0; tbl[1] = e1; tbl[2] = e2; tbl[3] = e3;
  endtask

  initial begin
    int          k;
    int          k2;
    int          r;
    int          sel;
    logic [15:0] v;

    apply_stimulus(CFG_END, CFG_END, CFG_END, CFG_END);
    reset_n = 1'b0;
    tick(3);
    reset_n = 1'b1;
    tick(2);

    // Two writes, slow engine; first start four cycles after cfg_start.
    busy_len = 50;
    apply_stimulus(16'h1280, 16'h1204, CFG_END, 16'h0000);
    pulse_start(k);
    wait_done("pass_a", 3000);
    check_output("a_writes", 32'(obs_log.size()), 2);
    if (obs_log.size() == 2) begin
      check_output("a_wr0", 32'(obs_log[0]), 32'h1280);
      check_output("a_wr1", 32'(obs_log[1]), 32'h1204);
      check_output("a_latency", 32'(start_cycles[0] - k), 4);
    end
    check_output("a_count", 32'(entry_count), 2);
    check_output("a_done", 32'(cfg_done), 1);
    check_output("a_busy", 32'(cfg_busy), 0);

    // Pause marker first: DECODE at k+2, DELAY_CYC pause, then NEXT/FETCH/DECODE/WAIT_RDY/ISSUE.
    apply_stimulus(CFG_DELAY, 16'h1100, CFG_END, 16'h0000);
    pulse_start(k);
    wait_done("pass_b", 5000);
    check_output("b_writes", 32'(obs_log.size()), 1);
    if (obs_log.size() == 1) begin
      check_output("b_wr0", 32'(obs_log[0]), 32'h1100);
      check_output("b_start_cycle", 32'(start_cycles[0] - k), 32'(2 + DELAY_CYC + 5));
    end

    // Restart while busy is ignored; restart after done repeats the pass.
    busy_len = 30;
    apply_stimulus(16'h1280, 16'h1204, 16'h3A04, CFG_END);
    pulse_start(k);
    wait_writes(1, 500);
    pulse_start(k2);
    wait_done("pass_c", 3000);
    check_output("c_writes", 32'(obs_log.size()), 3);
    check_output("c_count", 32'(entry_count), 3);
    pulse_start(k);
    check_output("c_restart_addr", 32'(rom_addr), 0);
    check_output("c_restart_done", 32'(cfg_done), 0);
    wait_done("pass_c2", 3000);
    check_output("c2_writes", 32'(obs_log.size()), 3);

    // Reset while the second write is in WAIT_DONE.
    busy_len = 40;
    pulse_start(k);
    wait_writes(2, 500);
    tick(5);
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    tick(60);
    check_output("post_reset_busy", 32'(cfg_busy), 0);
    check_output("post_reset_count", 32'(entry_count), 0);

    // Engine holds ready low for 200 cycles after reset; start follows its release by one cycle.
    reset_n = 1'b0;
    hold_low = 1'b1;
    tick(1);
    reset_n = 1'b1;
    apply_stimulus(16'h1280, 16'h1204, CFG_END, 16'h0000);
    tick(1);
    pulse_start(k);
    tick(198);
    check_output("hold_no_start", 32'(obs_log.size()), 0);
    r = cyc;
    hold_low = 1'b0;
    wait_done("pass_hold", 3000);
    check_output("hold_writes", 32'(obs_log.size()), 2);
    if (obs_log.size() > 0) check_output("hold_first_start", 32'(start_cycles[0] - r), 1);

    // No end marker: all four entries written, address stops at 3, count wraps in ROM_AW bits.
    busy_len = 10;
    apply_stimulus(16'h0101, 16'h0202, 16'h0303, 16'h0404);
    pulse_start(k);
    wait_done("pass_full", 3000);
    check_output("full_writes", 32'(obs_log.size()), 4);
    if (obs_log.size() == 4) check_output("full_wr3", 32'(obs_log[3]), 32'h0404);
    check_output("full_addr", 32'(rom_addr), 3);
    check_output("full_count", 32'(entry_count), 0);

    // Head of the production table.
    use_prod = 1'b1;
    pulse_start(k);
    wait_done("pass_prod", 5000);
    check_output("prod_writes", 32'(obs_log.size()), 3);
    if (obs_log.size() == 3) check_output("prod_wr2", 32'(obs_log[2]), 32'h1100);
    use_prod = 1'b0;

    for (int p = 0; p < 10; p++) begin
      for (int i = 0; i < DEPTH; i++) begin
        sel = $urandom_range(0, 9);
        v = 16'($urandom);
        if (v == CFG_END || v == CFG_DELAY) v = 16'h1234;
        if (sel == 0)      v = CFG_END;
        else if (sel == 1) v = CFG_DELAY;
        tbl[i] = v;
      end
      busy_len = $urandom_range(1, 60);
      pulse_start(k);
      if ($urandom_range(0, 1) == 1) begin
        tick($urandom_range(1, 40));
        if (cfg_busy) pulse_start(k2);
      end
      wait_done("rand_pass", 6000);
    end

    tick(5);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete, got cycle %0d, expected finish", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/ov7670_config_seq.md
Name: ov7670_config_seq

Overview:
- Upstream sequencer for the SCCB write engine; walks a register/value table in a synchronous ROM and issues one SCCB write per entry through the engine's start/ready handshake.
- Honours in-table delay and end markers, then reports completion.
- Sits between the top-level camera bring-up control and the SCCB write engine.

Parameters:
- CLK_FREQ, 25000000, clk frequency in Hz.
- DELAY_MS, 10, length of one delay-marker pause in milliseconds.
- ROM_AW, 8, table address width.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset.
- cfg_start  in  1  one-cycle pulse; begins a configuration pass from table entry 0.
- cfg_busy  out  1  high while a pass is in progress.
- cfg_done  out  1  high after the end marker is reached; held until the next accepted cfg_start or reset.
- rom_addr  out  ROM_AW  table address.
- rom_data  in  16  table entry: [15:8] register address, [7:0] value; valid 1 cycle after rom_addr changes.
- sccb_ready  in  1  write engine idle.
- sccb_start  out  1  one-cycle write request.
- sccb_addr  out  8  register address to the write engine.
- sccb_data  out  8  register value to the write engine.
- entry_count  out  ROM_AW  number of SCCB writes issued in the current or last pass.

Behaviour:
- Reset is on clk, reset_n synchronous, active-low.
- Reset values: all outputs 0. State goes to IDLE.
- Reset mid-pass aborts at once. No sccb_start is issued in the reset cycle or the cycle after it. The write engine's own reset handles any partial bus transfer.
- IDLE:
  - cfg_start=1 -> rom_addr=0, entry_count=0, cfg_done=0, cfg_busy=1, go to FETCH.
  - Otherwise stay in IDLE.
- FETCH: wait 1 cycle for ROM latency -> DECODE.
- DECODE, on rom_data:
  - 16'hFFFF -> DONE.
  - 16'hFFF0 -> load delay counter with CLK_FREQ/1000*DELAY_MS - 1, go to DELAY.
  - Any other value -> latch sccb_addr/sccb_data, go to WAIT_RDY.
- WAIT_RDY: hold until sccb_ready=1, then go to ISSUE.
- ISSUE: sccb_start=1 for exactly this cycle, entry_count+1 -> WAIT_ACCEPT.
- WAIT_ACCEPT: wait for sccb_ready=0. The write engine drops ready 1 cycle after it samples start. Then go to WAIT_DONE.
- WAIT_DONE: wait for sccb_ready=1, then go to NEXT.
- DELAY: decrement the counter; at 0 go to NEXT. Pause length from DECODE exit to NEXT is CLK_FREQ/1000*DELAY_MS cycles.
- NEXT:
  - If rom_addr is all-ones, the table is exhausted -> DONE.
  - Otherwise rom_addr+1 -> FETCH. No wrap-around is permitted.
- DONE: cfg_busy=0, cfg_done=1 -> IDLE.
- cfg_start while busy: ignored.
- cfg_start in IDLE with cfg_done=1: restarts the pass.
- sccb_start is never asserted while sccb_ready=0.
- sccb_addr/sccb_data are stable from DECODE exit until WAIT_DONE exit.
- Delay counter: 32 bits unsigned.
- Latency from cfg_start to the first sccb_start, with sccb_ready=1: 4 cycles (IDLE->FETCH->DECODE->WAIT_RDY->ISSUE).

Decomposition:
- Shared package ov7670_cfg_pkg:
  - Constants CFG_END=16'hFFFF and CFG_DELAY=16'hFFF0.
  - State encoding localparams.
  - Camera write address 8'h42 (shared with the write engine).
- One natural sub-module, ov7670_config_rom:
  - Synchronous ROM, ROM_AW address bits, 16-bit data, 1-cycle read latency.
  - Holds the camera register table terminated by CFG_END.
  - Instantiated beside the sequencer at top level, not inside it, so benches can substitute tables.

Test Plan:
- Table {1280, 1204, FFFF}, write-engine model ready low for 50 cycles per write, cfg_start pulse -> exactly two sccb_start pulses carrying (12,80) then (12,04). Then cfg_done=1, cfg_busy=0, entry_count=2.
- Table {FFF0, 1100, FFFF}, CLK_FREQ=1000000, DELAY_MS=1 -> the single sccb_start comes no earlier than 1000 cycles after DECODE of entry 0. Its data is (11,00).
- Model holds sccb_ready=0 for 200 cycles after reset, then the pass starts -> no sccb_start until sccb_ready rises. First start lands in ISSUE the cycle after WAIT_RDY sees ready=1.
- Second cfg_start mid-pass -> ignored, entry_count unaffected. After cfg_done, a third cfg_start -> rom_addr=0, cfg_done=0, and the full pass repeats.
- reset_n=0 during WAIT_DONE of entry 1 -> next cycle all outputs 0 and state IDLE. No sccb_start until a new cfg_start.
- ROM_AW=2, table {0101,0202,0303,0404} with no end marker -> 4 writes, then cfg_done=1. rom_addr never wraps to 0.
